// File: rtl/cloneless_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cloneless_bus_arbiter
//
// Host-pad bus controller and round-robin arbiter for the Cloneless core's
// shared register bank (2^AW entries of DW bits).
//
// The pad-level strobes, address and data are synchronized into clk. Each
// rising strobe edge becomes one single-cycle bank access. The bank is shared
// between that host port and one internal core requester.
//
// Build option:
//   PAD_SYNC_EN  defined   : 2-flop synchronizer on every pad input.
//   PAD_SYNC_EN  undefined : single capture flop. Host latency is one cycle
//                            shorter and there is no metastability margin.
//
// Parameters:
//   AW  address width (bank depth 2^AW)
//   DW  data width
//
// Ports:
//   clk          single clock
//   rst          asynchronous active-high reset
//   read, write  host strobes from the pad (asynchronous to clk)
//   address      host address from the pad
//   data_in      host write data from the pad
//   data_out     registered result of the last host read
//   host_drop    one-cycle pulse when a host strobe edge is discarded
//   core_req     core access request, held until granted
//   core_we      core write enable (qualified by core_req)
//   core_addr    core address
//   core_wdata   core write data
//   core_gnt     combinational grant; the access executes at this clock edge
//   core_rdata   registered core read data
//   core_rvalid  one-cycle pulse the cycle after a granted core read
// -----------------------------------------------------------------------------
module cloneless_bus_arbiter #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          read,
    input  logic          write,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          host_drop,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic [DW-1:0] core_rdata,
    output logic          core_rvalid
);

    localparam int unsigned Depth = 1 << AW;

`ifdef PAD_SYNC_EN
    localparam logic [1:0] SyncStages = 2'd2;
`else
    localparam logic [1:0] SyncStages = 2'd1;
`endif

    typedef enum logic {
        GntCore = 1'b0,
        GntHost = 1'b1
    } gnt_e;

    // -------------------------------------------------------------------------
    // Pad input conditioning
    // -------------------------------------------------------------------------
    // Address and data are synchronized bit-wise without coding; this is safe
    // only because the host keeps them stable from a cycle before the strobe
    // rises until it falls, so they are settled by the time the strobe edge
    // is seen.
    logic          rd_s;
    logic          wr_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] data_s;

`ifdef PAD_SYNC_EN
    logic          rd_m;
    logic          wr_m;
    logic [AW-1:0] addr_m;
    logic [DW-1:0] data_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_m   <= 1'b0;
            wr_m   <= 1'b0;
            addr_m <= '0;
            data_m <= '0;
            rd_s   <= 1'b0;
            wr_s   <= 1'b0;
            addr_s <= '0;
            data_s <= '0;
        end else begin
            rd_m   <= read;
            wr_m   <= write;
            addr_m <= address;
            data_m <= data_in;
            rd_s   <= rd_m;
            wr_s   <= wr_m;
            addr_s <= addr_m;
            data_s <= data_m;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_s   <= 1'b0;
            wr_s   <= 1'b0;
            addr_s <= '0;
            data_s <= '0;
        end else begin
            rd_s   <= read;
            wr_s   <= write;
            addr_s <= address;
            data_s <= data_in;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Edge detection
    // -------------------------------------------------------------------------
    // The synchronizer comes out of reset holding 0, so a strobe that is
    // still high at reset release would look like a fresh rising edge. The
    // fill counter marks when the synchronized strobes reflect the pads, and
    // each strobe is armed only after it has been seen low from then on.
    logic [1:0] fill_q;
    logic       sync_ok;
    logic       rd_d;
    logic       wr_d;
    logic       rd_armed;
    logic       wr_armed;
    logic       rd_edge;
    logic       wr_edge;
    logic       any_edge;

    assign sync_ok = (fill_q == SyncStages);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q   <= 2'd0;
            rd_d     <= 1'b0;
            wr_d     <= 1'b0;
            rd_armed <= 1'b0;
            wr_armed <= 1'b0;
        end else begin
            if (!sync_ok) begin
                fill_q <= fill_q + 2'd1;
            end
            rd_d     <= rd_s;
            wr_d     <= wr_s;
            rd_armed <= rd_armed | (sync_ok & ~rd_s);
            wr_armed <= wr_armed | (sync_ok & ~wr_s);
        end
    end

    assign rd_edge  = rd_s & ~rd_d & rd_armed;
    assign wr_edge  = wr_s & ~wr_d & wr_armed;
    assign any_edge = rd_edge | wr_edge;

    // -------------------------------------------------------------------------
    // Host request capture
    // -------------------------------------------------------------------------
    logic          host_pend;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          core_gnt_w;
    gnt_e          last_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_pend  <= 1'b0;
            host_we    <= 1'b0;
            host_addr  <= '0;
            host_wdata <= '0;
            host_drop  <= 1'b0;
        end else begin
            host_drop <= any_edge & host_pend;
            if (any_edge && !host_pend) begin
                host_pend  <= 1'b1;
                // A simultaneous read edge is ignored in favour of the write.
                host_we    <= wr_edge;
                host_addr  <= addr_s;
                host_wdata <= data_s;
            end else if (host_gnt) begin
                host_pend <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin arbitration
    // -------------------------------------------------------------------------
    // On a conflict the requester that did not win last time is served.
    // core_gnt is forced low during reset so every output reads 0 at once.
    assign host_gnt   = host_pend & (~core_req | (last_gnt == GntCore));
    assign core_gnt_w = core_req & ~rst & (~host_pend | (last_gnt == GntHost));
    assign core_gnt   = core_gnt_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= GntCore;
        end else if (host_gnt) begin
            last_gnt <= GntHost;
        end else if (core_gnt_w) begin
            last_gnt <= GntCore;
        end
    end

    // -------------------------------------------------------------------------
    // Register bank and read ports
    // -------------------------------------------------------------------------
    logic [DW-1:0] bank [Depth];
    logic          bank_we;
    logic [AW-1:0] bank_waddr;
    logic [DW-1:0] bank_wdata;

    // Grants are mutually exclusive, so at most one access happens per edge.
    always_comb begin
        bank_we    = 1'b0;
        bank_waddr = '0;
        bank_wdata = '0;
        if (host_gnt) begin
            bank_we    = host_we;
            bank_waddr = host_addr;
            bank_wdata = host_wdata;
        end else if (core_gnt_w) begin
            bank_we    = core_we;
            bank_waddr = core_addr;
            bank_wdata = core_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                bank[i] <= '0;
            end
        end else if (bank_we) begin
            bank[bank_waddr] <= bank_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (host_gnt && !host_we) begin
            data_out <= bank[host_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rdata  <= '0;
            core_rvalid <= 1'b0;
        end else begin
            core_rvalid <= core_gnt_w & ~core_we;
            if (core_gnt_w && !core_we) begin
                core_rdata <= bank[core_addr];
            end
        end
    end

endmodule

// File: tb/tb_cloneless_bus_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for cloneless_bus_arbiter: directed scenarios plus a
// randomized host/core access mix checked against an array model of the bank.
module tb_cloneless_bus_arbiter;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 4;
`ifdef PAD_SYNC_EN
    localparam int Lat = 4;
`else
    localparam int Lat = 3;
`endif

    logic          clk;
    logic          rst;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          host_drop;
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic [DW-1:0] core_rdata;
    logic          core_rvalid;

    cloneless_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .read       (read),
        .write      (write),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .host_drop  (host_drop),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rdata (core_rdata),
        .core_rvalid(core_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_low  = 0;
    int drop_cnt = 0;
    logic rv_exp = 1'b0;

    logic [DW-1:0] m_bank [8];
    logic [DW-1:0] m_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From one falling edge to the next, passing exactly one active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_bank[i] = '0;
        m_dout = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        model_clear();
    endtask

    // One complete host transaction obeying the pad protocol.
    task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        address = a;
        data_in = d;
        tick();
        if (we) write = 1'b1;
        else    read  = 1'b1;
        repeat (4) tick();
        write = 1'b0;
        read  = 1'b0;
        repeat (4) tick();
        if (we) m_bank[a] = d;
        else    m_dout    = m_bank[a];
        check("host_data_out", data_out, m_dout);
    endtask

    // One uncontended core access.
    task automatic core_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_we    = we;
        core_addr  = a;
        core_wdata = d;
        core_req   = 1'b1;
        #1;
        check("core_gnt_same_cycle", core_gnt, 1);
        tick();
        core_req = 1'b0;
        if (we) begin
            m_bank[a] = d;
        end else begin
            check("core_rvalid_pulse", core_rvalid, 1);
            check("core_rdata", core_rdata, m_bank[a]);
        end
        tick();
        check("core_rvalid_low", core_rvalid, 0);
    endtask

    // Per-cycle protocol monitor: rvalid follows each granted core read by one
    // cycle; also tallies lost core cycles and host_drop pulses.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            rv_exp = 1'b0;
        end else begin
            check("rvalid_follows_grant", core_rvalid, rv_exp);
            rv_exp = core_gnt & ~core_we;
            if (core_req && !core_gnt) gnt_low++;
            if (host_drop) drop_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic          we_r;
        logic [AW-1:0] a_r;
        logic [DW-1:0] d_r;
        int            op;

        rst        = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        data_in    = '0;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_data_out", data_out, 0);
        check("rst_core_rdata", core_rdata, 0);
        check("rst_core_rvalid", core_rvalid, 0);
        check("rst_host_drop", host_drop, 0);
        check("rst_core_gnt", core_gnt, 0);

        // Host write 0xA to 5, then read with exact latency
        host_op(1'b1, 3'd5, 4'hA);
        address = 3'd5;
        tick();
        read = 1'b1;
        repeat (Lat - 1) tick();
        check("lat_before", data_out, 0);
        tick();
        check("lat_exact", data_out, 4'hA);
        repeat (3) tick();
        read = 1'b0;
        repeat (4) tick();
        m_dout = 4'hA;

        // Core write seen by host
        core_op(1'b1, 3'd2, 4'h3);
        host_op(1'b0, 3'd2, 4'h0);
        check("share_read", data_out, 4'h3);

        // Same-cycle strobes: write wins, data_out untouched
        address = 3'd1;
        data_in = 4'h7;
        tick();
        read  = 1'b1;
        write = 1'b1;
        repeat (4) tick();
        check("same_cycle_dout_hold", data_out, m_dout);
        read  = 1'b0;
        write = 1'b0;
        repeat (4) tick();
        m_bank[1] = 4'h7;
        host_op(1'b0, 3'd1, 4'h0);

        // Dropped edge while a host read is pending and loses one conflict
        host_op(1'b1, 3'd4, 4'h9);
        address = 3'd4;
        data_in = 4'hF;
        tick();
        read = 1'b1;
        tick();
        write    = 1'b1;
        drop_cnt = 0;
        repeat (Lat - 2) tick();
        core_we   = 1'b0;
        core_addr = 3'd6;
        core_req  = 1'b1;
        #1;
        check("drop_core_wins", core_gnt, 1);
        tick();
        check("drop_host_wins", core_gnt, 0);
        check("drop_core_rvalid", core_rvalid, 1);
        check("drop_core_rdata", core_rdata, m_bank[6]);
        core_req = 1'b0;
        tick();
        check("drop_read_result", data_out, m_bank[4]);
        repeat (2) tick();
        read  = 1'b0;
        write = 1'b0;
        repeat (4) tick();
        check("drop_pulse_count", drop_cnt, 1);
        m_dout = m_bank[4];
        host_op(1'b0, 3'd4, 4'h0);

        // Randomized uncontended mix
        repeat (30) begin
            op  = int'($urandom_range(0, 3));
            a_r = AW'($urandom_range(0, 7));
            d_r = DW'($urandom_range(0, 15));
            case (op)
                0:       host_op(1'b1, a_r, d_r);
                1:       host_op(1'b0, a_r, d_r);
                2:       core_op(1'b1, a_r, d_r);
                default: core_op(1'b0, a_r, d_r);
            endcase
        end

        // Asynchronous reset mid-cycle, then a strobe held across reset release
        host_op(1'b1, 3'd7, 4'hE);
        host_op(1'b0, 3'd7, 4'h0);
        core_we   = 1'b0;
        core_addr = 3'd7;
        core_req  = 1'b1;
        @(posedge clk);
        #3;
        check("pre_rst_rvalid", core_rvalid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_data_out", data_out, 0);
        check("async_rst_core_rdata", core_rdata, 0);
        check("async_rst_core_rvalid", core_rvalid, 0);
        check("async_rst_host_drop", host_drop, 0);
        check("async_rst_core_gnt", core_gnt, 0);
        @(negedge clk);
        core_req = 1'b0;
        address  = 3'd0;
        data_in  = 4'hC;
        write    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        write = 1'b0;
        repeat (4) tick();
        model_clear();
        for (int i = 0; i < 8; i++) host_op(1'b0, AW'(i), 4'h0);

        // First conflict after reset goes to the host, then grants alternate
        do_reset();
        address = 3'd3;
        data_in = 4'h5;
        tick();
        write = 1'b1;
        repeat (Lat - 1) tick();
        core_we   = 1'b0;
        core_addr = 3'd3;
        core_req  = 1'b1;
        #1;
        check("conflict_first_host", core_gnt, 0);
        tick();
        check("conflict_then_core", core_gnt, 1);
        m_bank[3] = 4'h5;
        tick();
        check("conflict_core_rvalid", core_rvalid, 1);
        check("conflict_core_rdata", core_rdata, 4'h5);
        tick();
        write = 1'b0;
        repeat (4) tick();

        repeat (8) begin
            we_r    = 1'($urandom_range(0, 1));
            a_r     = AW'($urandom_range(0, 7));
            d_r     = DW'($urandom_range(0, 15));
            gnt_low = 0;
            host_op(we_r, a_r, d_r);
            check("contention_one_wait", gnt_low, 1);
        end
        check("contention_core_rdata", core_rdata, m_bank[3]);
        core_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cloneless_bus_arbiter.md
# cloneless_bus_arbiter

Host-pad bus controller and arbiter for the Cloneless core's shared 8×4-bit register bank. It conditions the pad-level `read`/`write` strobes, `address` and `data_in`, and turns strobe rising edges into single-cycle bank accesses. It shares the bank between that host port and one internal core requester using round-robin arbitration, and drives `data_out` with the last host read result. It sits directly between the pad-ring input cells and the Cloneless datapath.

## Interface
Parameters:
- `AW`, 3, address width; bank depth is 2^AW.
- `DW`, 4, data width.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `read` in 1: host read strobe from the pad; asynchronous to `clk`.
- `write` in 1: host write strobe from the pad; asynchronous to `clk`.
- `address` in AW: host address from the pad.
- `data_in` in DW: host write data from the pad.
- `data_out` out DW: registered result of the last host read.
- `host_drop` out 1: one-cycle pulse when a host strobe edge is discarded.
- `core_req` in 1: core access request; held until granted.
- `core_we` in 1: core write enable; qualified by `core_req`.
- `core_addr` in AW: core address.
- `core_wdata` in DW: core write data.
- `core_gnt` out 1: combinational grant; the access executes at this clock edge.
- `core_rdata` out DW: core read data, registered.
- `core_rvalid` out 1: one-cycle pulse the cycle after a granted core read.

## Operation
- Input conditioning: `read`, `write`, `address` and `data_in` pass through the synchronizer described under Configuration.
- Edge detection: a delayed copy of the synchronized strobes feeds the edge detector. `rd_edge = rd_s & ~rd_d`; `wr_edge` is formed the same way.
- Host capture:
  - On `wr_edge` or `rd_edge` with no host request pending, latch op, synchronized address and synchronized data, and set `host_pend`.
  - If `wr_edge` and `rd_edge` occur in the same cycle, the write is taken and the read is ignored.
  - Any edge that arrives while `host_pend` = 1 is discarded and pulses `host_drop`.
- Arbitration is evaluated every cycle:
  - Host only pending: grant host.
  - Core only requesting: grant core.
  - Both: grant the requester opposite to `last_gnt`.
  - `last_gnt` updates on every grant.
- Granted access:
  - Write: updates the bank entry at the clock edge.
  - Host read: loads `data_out` at the same edge and clears `host_pend`. `data_out` holds that value until the next host read.
  - Core read: loads `core_rdata` and pulses `core_rvalid`.
  - Read data is the bank contents before any write at that edge; only one access occurs per cycle.
- Addresses index the bank directly. All 2^AW entries are valid, so no out-of-range case exists.
- Reset values:
  - Bank all 0; `data_out` = 0; `core_rdata` = 0.
  - `core_rvalid` = 0; `host_drop` = 0; `core_gnt` = 0.
  - `host_pend` = 0; all synchronizer and edge flops = 0.
  - `last_gnt` = core, so the host wins the first conflict.
- Reset mid-operation: a pending host request is discarded. A strobe that is still high when reset releases does not produce an edge until it falls and rises again.

## Timing
Host access latency (strobe rising edge to `data_out` or bank update), uncontended:
- 4 clock edges with `PAD_SYNC_EN`.
- 3 clock edges without it.
- Under contention, at most 1 additional cycle.

Core access:
- `core_gnt` is asserted in the same cycle as `core_req` when uncontended.
- `core_rvalid` and `core_rdata` arrive 1 cycle after the grant.
- Under contention, at most 1 cycle of wait.

Host protocol:
- `address` and `data_in` are stable from 1 cycle before the strobe rises until the strobe falls.
- Strobe high and low times are each ≥ 3 clk periods.
- Both `read` and `write` low between accesses.

## Configuration
- `PAD_SYNC_EN` defined: the pad inputs use a 2-flop synchronizer.
- `PAD_SYNC_EN` undefined: the pad inputs use a single capture flop; host latency shrinks by 1 cycle and there is no metastability margin.
- Function is otherwise identical in both builds.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; a read of every address returns 0.
- Host write then read:
  - Write 0xA to address 5, then read address 5.
  - With `PAD_SYNC_EN`, `data_out` = 0xA exactly 4 edges after the `read` rise.
  - Without `PAD_SYNC_EN`, this happens after 3 edges.
- Core/host sharing:
  - Core writes 0x3 to address 2 → `core_gnt` is high the same cycle.
  - A subsequent host read of address 2 → `data_out` = 0x3.
- Contention:
  - Hold `core_req` continuously while issuing host reads.
  - The first conflict grants the host; grants then alternate.
  - `core_rvalid` follows each core grant by 1 cycle.
- Same-cycle strobes and overlap:
  - Raise `read` and `write` in the same cycle with `data_in` = 0x7 at address 1 → a write occurs, `data_out` is unchanged, and a later read returns 0x7.
  - A second strobe edge while a host request is pending and contended → `host_drop` pulses once and the bank is unchanged by the dropped access.
